vblank_access_arbiter: RTL

- Shares one update port (sprite/board RAM write side) among N_REQ game-logic requesters.
- Access is granted only inside the vertical-blanking window, so the drawing pipeline never sees a half-updated frame.
- Consumes vblnk/vcount from the VGA timing stream; produces a one-hot grant per requester and a per-frame tick.
- Sits between the timing generator and the game-logic/drawing modules.

---
 rtl/vblank_access_arbiter_pkg.sv | 24 ++
 rtl/vblank_access_arbiter_if.sv | 26 ++
 rtl/vblank_access_arbiter_rr_pick.sv | 38 +++
 rtl/vblank_access_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/vblank_access_arbiter_pkg.sv
// Shared timing constants, arbiter state encoding and small index helpers
// for the vertical-blanking access arbiter.
package vblank_access_arbiter_pkg;

  // 800x600 frame: last vertical line index.
  localparam int VCOUNT_MAX         = 627;
  localparam int VBLANK_GUARD_LINES = 2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SEL,
    ARB_GRANT
  } arb_state_t;

  // Width of an index into n slots; never zero so single-entry vectors still work.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/vblank_access_arbiter_if.sv
// Timing-stream inputs plus the request/grant bundle shared by the
// requesters and the vblank arbiter.
interface vblank_access_arbiter_if #(
  parameter int N_REQ = 2
) ();

  logic             vblnk;
  logic [10:0]      vcount;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] gnt;
  logic             busy;
  logic             frame_tick;
  logic             abort;

  modport master (
    output vblnk, vcount, req, done,
    input  gnt, busy, frame_tick, abort
  );

  modport slave (
    input  vblnk, vcount, req, done,
    output gnt, busy, frame_tick, abort
  );

endinterface

// File: rtl/vblank_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible slot at or above ptr_i,
// wrapping, returned both one-hot and as an index.
module vblank_access_arbiter_rr_pick
  import vblank_access_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     eligible_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand [N];

  // Search order: ptr, ptr+1, ... wrapping modulo N.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cand[i] = IDX_W'((int'(ptr_i) + i) % N);
    end
  end

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid_o && eligible_i[cand[i]]) begin
        valid_o           = 1'b1;
        onehot_o[cand[i]] = 1'b1;
        idx_o             = cand[i];
      end
    end
  end

endmodule

// File: rtl/vblank_access_arbiter.sv
// Grants one requester at a time access to the shared update port, only
// while the vertical-blanking window is open; at most one grant per requester per frame.
module vblank_access_arbiter
  import vblank_access_arbiter_pkg::*;
#(
  parameter int N_REQ            = 2,
  parameter int GUARD_LINES      = VBLANK_GUARD_LINES,
  parameter int MAX_GRANT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  vblank_access_arbiter_if.slave bus
);

  localparam int               IDX_W     = idx_width(N_REQ);
  localparam int               TMR_W     = idx_width(MAX_GRANT_CYCLES);
  localparam logic [10:0]      WIN_LIMIT = 11'(VCOUNT_MAX - GUARD_LINES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(MAX_GRANT_CYCLES - 1);

  logic win_d, win_q, win_prev_q;
  logic tick_d, tick_q;

  arb_state_t       state_d, state_q;
  logic [N_REQ-1:0] gnt_d, gnt_q;
  logic [N_REQ-1:0] served_d, served_q;
  logic [IDX_W-1:0] owner_d, owner_q;
  logic [IDX_W-1:0] rr_ptr_d, rr_ptr_q;
  logic [TMR_W-1:0] timer_d, timer_q;
  logic             abort_d, abort_q;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [IDX_W-1:0] owner_next;

  assign win_d      = bus.vblnk && (bus.vcount < WIN_LIMIT);
  assign tick_d     = win_q & ~win_prev_q;
  assign eligible   = bus.req & ~served_q;
  assign owner_next = IDX_W'(wrap_inc(int'(owner_q), N_REQ));

  vblank_access_arbiter_rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .eligible_i (eligible),
    .ptr_i      (rr_ptr_q),
    .onehot_o   (pick_onehot),
    .idx_o      (pick_idx),
    .valid_o    (pick_valid)
  );

  // Window history resets to "open" so a window already open at reset release
  // produces no edge; the first tick needs the window to be seen closed first.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q      <= 1'b1;
      win_prev_q <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      win_q      <= win_d;
      win_prev_q <= win_q;
      tick_q     <= tick_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      served_q <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      timer_q  <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      served_q <= served_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q  <= timer_d;
      abort_q  <= abort_d;
    end
  end

  // NOTE: every variable gets its hold value first, so no path through the
  // case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    served_d = served_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    timer_d  = timer_q;
    abort_d  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (tick_q) begin
          served_d = '0;
          state_d  = ARB_SEL;
        end
      end

      ARB_SEL: begin
        if (!win_q) begin
          state_d = ARB_IDLE;
        end else if (pick_valid) begin
          gnt_d   = pick_onehot;
          owner_d = pick_idx;
          timer_d = '0;
          state_d = ARB_GRANT;
        end
      end

      ARB_GRANT: begin
        // A release by the owner takes priority over close and timeout.
        if (bus.done[owner_q]) begin
          gnt_d             = '0;
          served_d[owner_q] = 1'b1;
          rr_ptr_d          = owner_next;
          state_d           = ARB_SEL;
        end else if (!win_q || timer_q == TMR_LAST) begin
          gnt_d             = '0;
          served_d[owner_q] = 1'b1;
          rr_ptr_d          = owner_next;
          abort_d           = 1'b1;
          state_d           = win_q ? ARB_SEL : ARB_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.gnt        = gnt_q;
  assign bus.busy       = |gnt_q;
  assign bus.frame_tick = tick_q;
  assign bus.abort      = abort_q;

endmodule
